// File: rtl/float_to_int_pkg.sv
// Shared constants and state encoding for the float -> int32 converter.
// Holds exponent/fraction geometry, integer saturation limits and the
// one-hot controller encoding (same encoding as float_add).
// Optional feature macro: FLOAT_TO_INT_ROUND_EN (round to nearest even).
package float_to_int_pkg;

  localparam int BIAS   = 127;
  localparam int FRAC_W = 23;
  localparam int EXP_W  = 8;
  localparam int INT_W  = 32;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  // Smallest exponent whose value reaches 2^31 (out of int32 range).
  localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'(BIAS + 31);
  // Exponent at which {1,frac} already is the integer value (no shift).
  localparam logic [EXP_W-1:0] EXP_INT = EXP_W'(BIAS + FRAC_W);

  localparam logic [31:0] INT_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  // -2^31 as a float: the only e>=158 input that is exactly representable.
  localparam logic [31:0] FL_INT_MIN = 32'hCF00_0000;

  typedef enum logic [2:0] {
    ST_INIT = 3'b001,
    ST_CALC = 3'b010,
    ST_DONE = 3'b100
  } state_t;

endpackage

// File: rtl/float_classify.sv
// Combinational classifier for an IEEE-754 single operand.
// Ports: fl_in (operand) -> is_nan, is_inf (Inf or magnitude >= 2^31 other
// than exactly -2^31), is_zero_or_small (|x| < 1, result 0), is_int_min,
// shift_n (mantissa shift count), shift_left (shift direction).
// With FLOAT_TO_INT_ROUND_EN, e==BIAS-1 is a normal right shift of 24 so
// the rounding logic can see the guard bit.
module float_classify
  import float_to_int_pkg::*;
(
  input  logic [31:0] fl_in,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero_or_small,
  output logic        is_int_min,
  output logic        shift_left,
  output logic [4:0]  shift_n
);

  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] frac;

  assign e    = fl_in[30:23];
  assign frac = fl_in[22:0];

  always_comb begin
    is_nan     = (e == EXP_MAX) && (frac != '0);
    is_int_min = (fl_in == FL_INT_MIN);
    // e>=158 also covers e==255 with frac==0 (infinity).
    is_inf     = (e >= EXP_SAT) && !is_nan && !is_int_min;
`ifdef FLOAT_TO_INT_ROUND_EN
    is_zero_or_small = (e < EXP_W'(BIAS - 1));
`else
    is_zero_or_small = (e < EXP_W'(BIAS));
`endif
    shift_left = (e >= EXP_INT);
    if (shift_left) shift_n = 5'(e - EXP_INT);
    else            shift_n = 5'(EXP_INT - e);
  end

endmodule

// File: rtl/float_to_int.sv
// Iterative IEEE-754 single -> signed int32 converter, one mantissa shift
// per clock. Controller: INIT (wait start) -> CALC (n+1 edges) -> DONE
// (hold result until ack). Truncates toward zero; out-of-range and NaN
// inputs saturate and raise ovf.
// Ports: clk, rst (async active-low), start, ack, fl_in[31:0],
// int_out[31:0], ovf, done (state==DONE), busy (state==CALC).
// Optional macro FLOAT_TO_INT_ROUND_EN: round to nearest, ties to even,
// using a guard and sticky bit collected during right shifts.
module float_to_int
  import float_to_int_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ack,
  input  logic [31:0]      fl_in,
  output logic [INT_W-1:0] int_out,
  output logic             ovf,
  output logic             done,
  output logic             busy
);

  state_t state, state_nxt;

  logic        c_nan, c_inf, c_small, c_imin, c_left, c_special, c_spec_ovf;
  logic [4:0]  c_n;
  logic [31:0] c_spec_val;

  logic        s_q, left_q, special_q, spec_ovf_q;
  logic [4:0]  n_q;
  logic [31:0] mag_q, spec_val_q, mag_fin;

  float_classify u_cls (
    .fl_in            (fl_in),
    .is_nan           (c_nan),
    .is_inf           (c_inf),
    .is_zero_or_small (c_small),
    .is_int_min       (c_imin),
    .shift_left       (c_left),
    .shift_n          (c_n)
  );

  assign c_special  = c_nan | c_inf | c_small | c_imin;
  assign c_spec_ovf = c_nan | c_inf;

  always_comb begin
    c_spec_val = '0;
    if (c_nan || c_imin) c_spec_val = INT_MIN;
    else if (c_inf)      c_spec_val = fl_in[31] ? INT_MIN : INT_MAX;
  end

`ifdef FLOAT_TO_INT_ROUND_EN
  logic guard_q, sticky_q;
  // Ties go to the even neighbour: round up only past half, or at exactly
  // half when the kept LSB is odd.
  assign mag_fin = mag_q + {31'd0, guard_q & (sticky_q | mag_q[0])};
`else
  assign mag_fin = mag_q;
`endif

  assign done = (state == ST_DONE);
  assign busy = (state == ST_CALC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (start)      state_nxt = ST_CALC;
      ST_CALC: if (n_q == '0)  state_nxt = ST_DONE;
      ST_DONE: if (ack)        state_nxt = ST_INIT;
      default:                 state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q        <= 1'b0;
      left_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_ovf_q <= 1'b0;
      spec_val_q <= '0;
      n_q        <= '0;
      mag_q      <= '0;
      int_out    <= '0;
      ovf        <= 1'b0;
`ifdef FLOAT_TO_INT_ROUND_EN
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_INIT: if (start) begin
          s_q        <= fl_in[31];
          left_q     <= c_left;
          special_q  <= c_special;
          spec_ovf_q <= c_spec_ovf;
          spec_val_q <= c_spec_val;
          n_q        <= c_special ? 5'd0 : c_n;
          mag_q      <= {8'd0, 1'b1, fl_in[22:0]};
`ifdef FLOAT_TO_INT_ROUND_EN
          guard_q    <= 1'b0;
          sticky_q   <= 1'b0;
`endif
        end
        ST_CALC: begin
          if (n_q != '0) begin
            n_q <= n_q - 5'd1;
            if (left_q) begin
              mag_q <= mag_q << 1;
            end else begin
              mag_q <= mag_q >> 1;
`ifdef FLOAT_TO_INT_ROUND_EN
              guard_q  <= mag_q[0];
              sticky_q <= sticky_q | guard_q;
`endif
            end
          end else begin
            // mag_fin < 2^31 on the normal path, so negation cannot overflow.
            if (special_q) int_out <= spec_val_q;
            else           int_out <= s_q ? (~mag_fin + 32'd1) : mag_fin;
            ovf <= spec_ovf_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: the driver pushes the expected
// result/flag/CALC length per conversion; a negedge monitor pops and
// compares whenever done rises and checks the result stays held in DONE.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, ack;
  logic [31:0] fl_in;
  logic [31:0] int_out;
  logic        ovf, done, busy;

  float_to_int dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ack     (ack),
    .fl_in   (fl_in),
    .int_out (int_out),
    .ovf     (ovf),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic        o;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef FLOAT_TO_INT_ROUND_EN
  localparam logic [31:0] E_0625 = 32'h0000_0001; localparam int L_0625 = 25;
  localparam logic [31:0] E_M35  = 32'hFFFF_FFFC;
  localparam logic [31:0] E_M15  = 32'hFFFF_FFFE;
  localparam int          L_M05  = 25;
`else
  localparam logic [31:0] E_0625 = 32'h0000_0000; localparam int L_0625 = 1;
  localparam logic [31:0] E_M35  = 32'hFFFF_FFFD;
  localparam logic [31:0] E_M15  = 32'hFFFF_FFFF;
  localparam int          L_M05  = 1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: counts CALC cycles, checks result on done rise and holding.
  int   bcnt = 0;
  bit   seen = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst) begin
      bcnt = 0; seen = 0;
    end else if (busy) begin
      bcnt++;
    end else if (done) begin
      if (!seen) begin
        seen = 1;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          cur = sb_q.pop_front();
          chk("result", int_out, cur.v);
          chk("ovf", {31'd0, ovf}, {31'd0, cur.o});
          chk("latency", bcnt, cur.lat);
        end
        bcnt = 0;
      end else begin
        chk("hold_result", int_out, cur.v);
        chk("hold_ovf", {31'd0, ovf}, {31'd0, cur.o});
      end
    end else begin
      bcnt = 0; seen = 0;
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // One conversion. poke=1 pulses start (other operand) mid-CALC and in DONE.
  task automatic run(input logic [31:0] f, input logic [31:0] ev, input logic eo,
                     input int lat, input int hold, input bit poke);
    sb_q.push_back('{ev, eo, lat});
    fl_in = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1; fl_in = 32'h4F00_0000; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    wait_done();
    if (poke) begin
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
    end
    repeat (hold) @(posedge clk);
    #1; ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
    chk("done_after_ack", {31'd0, done}, 32'd0);
    chk("busy_after_ack", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ack = 1'b0; fl_in = '0;
    #1;
    chk("rst_int_out", int_out, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;

    run(32'h3F20_0000, E_0625,       1'b0, L_0625, 0, 0); // 0.625
    run(32'h42F6_0000, 32'h0000_007B, 1'b0, 18,    5, 0); // 123.0
    run(32'hC060_0000, E_M35,        1'b0, 23,     0, 0); // -3.5
    run(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1,     0, 0); // 2^31
    run(32'hCF00_0000, 32'h8000_0000, 1'b0, 1,     0, 0); // -2^31
    run(32'h7F80_0001, 32'h8000_0000, 1'b1, 1,     0, 0); // NaN
    run(32'hFF80_0000, 32'h8000_0000, 1'b1, 1,     0, 0); // -Inf
    run(32'h0000_0000, 32'h0000_0000, 1'b0, 1,     0, 0); // +0
    run(32'h3F80_0000, 32'h0000_0001, 1'b0, 24,    0, 0); // 1.0
    run(32'hBFC0_0000, E_M15,        1'b0, 24,     0, 0); // -1.5
    run(32'h4020_0000, 32'h0000_0002, 1'b0, 23,    0, 0); // 2.5
    run(32'hBF00_0000, 32'h0000_0000, 1'b0, L_M05, 0, 0); // -0.5
    run(32'h4B00_0000, 32'h0080_0000, 1'b0, 1,     0, 0); // 2^23, n=0
    run(32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 8,     0, 0); // largest negative
    run(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 8,     1, 0); // largest positive

    // Asynchronous reset in the middle of a long conversion.
    fl_in = 32'h3F80_0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst = 1'b0; #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_int_out", int_out, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    run(32'h4040_0000, 32'h0000_0003, 1'b0, 23, 0, 0);  // 3.0

    // start pulses during CALC and DONE must not disturb 123.0.
    run(32'h42F6_0000, 32'h0000_007B, 1'b0, 18, 2, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter.
- Sits directly downstream of float_add and consumes its 32-bit result using the same start/ack handshake.
- Iterative: one mantissa shift per clock, with a 3-state controller (INIT, CALC, DONE).
- Default rounding is truncation toward zero. Out-of-range inputs saturate and are flagged.

Parameters:
- BIAS, 127, exponent bias.
- FRAC_W, 23, stored fraction width.
- INT_W, 32, integer result width (fixed at 32; the parameter exists for documentation only).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous active-low reset (asserted when 0).
- start  in  1  request conversion; sampled only in INIT.
- ack  in  1  consumer acknowledges result; sampled only in DONE.
- fl_in  in  32  float operand; sampled on the same edge that samples start=1.
- int_out  out  32  signed two's-complement result; valid while done=1.
- ovf  out  1  range/NaN flag; valid while done=1.
- done  out  1  high exactly while the state is DONE.
- busy  out  1  high exactly while the state is CALC.

Behaviour:
- Reset (rst=0, asynchronous): state goes to INIT. int_out=0, ovf=0, done=0, busy=0, and all internal registers are cleared. This holds regardless of the current state, including mid-CALC. Any in-flight conversion is discarded.
- INIT, start=1 at an edge:
  - latch sign s, exponent e and magnitude register mag={1,frac} zero-extended to 32 bits;
  - compute shift count n and direction;
  - go to CALC.
  - start=0 keeps the state in INIT.
- Classification at latch time:
  - e==255, frac!=0 (NaN): special result 0x80000000, ovf=1.
  - e==255, frac==0 (Inf): or e>=158 and not exactly -2^31: special result 0x7FFFFFFF if s=0, else 0x80000000; ovf=1.
  - 0xCF000000 (exactly -2^31): special result 0x80000000, ovf=0.
  - e<127 (includes zero and denormals): special result 0, ovf=0.
  - Otherwise normal. E=e-150:
    - E>=0: left shift, n=E (0..7);
    - E<0: right shift, n=-E (1..23).
- Special results force n=0.
- CALC, each edge:
  - n!=0: shift mag one bit in the latched direction; n=n-1.
  - n==0: load int_out (special value, or mag negated if s=1); load ovf; go to DONE.
  - Shift bits shifted out on the right are discarded (truncation).
- Latency: the CALC stage lasts n+1 edges. done rises on the (n+1)th edge after the start-sampling edge.
  - Worst case: n=23, 24 edges.
  - Specials: 1 edge.
- DONE: int_out and ovf are held stable.
  - ack=1 at an edge: go to INIT. done=0 next cycle; int_out and ovf keep their values until the next CALC completion.
  - ack=0: stay in DONE.
- start asserted outside INIT is ignored. ack asserted outside DONE is ignored.
- start=1 held continuously causes back-to-back conversions, with one INIT cycle between them.
- Arithmetic: the negation is 32-bit two's complement. mag never exceeds 2^31-1 on the normal path, so the negation cannot overflow.

Optional Feature:
- Macro: FLOAT_TO_INT_ROUND_EN.
- Defined:
  - Round to nearest, ties to even, replaces truncation.
  - A guard bit and a sticky bit are kept during right shifts.
  - At finalize, mag is incremented if guard & (sticky | mag[0]), before negation.
  - e==126 is treated as a normal right shift with n=24; e<126 still yields 0.
  - Latency grows by at most 1 edge (n=24).
- Undefined: truncation toward zero. No guard or sticky logic is synthesized.

Decomposition:
- Shared package/include holds:
  - BIAS, FRAC_W, EXP_W=8, EXP_MAX=255;
  - INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000;
  - state encoding for INIT/CALC/DONE (one-hot, matching float_add).
- One natural sub-module: float_classify. It is combinational: fl_in in; is_nan, is_inf, is_zero_or_small, is_int_min, shift count and direction out. It is instantiated in the INIT latch path.

Test Plan:
1. 0x3F200000 (0.625, the float_add result for 0.5+0.125), start for 1 cycle:
   - without macro: int_out=0x00000000, ovf=0;
   - with macro: int_out=0x00000001.
2. 0x42F60000 (123.0), n=17: done rises 18 edges after the start edge; int_out=0x0000007B. Hold ack=0 for 5 cycles: outputs remain stable. Pulse ack: done=0 next cycle.
3. 0xC0600000 (-3.5):
   - without macro: int_out=0xFFFFFFFD;
   - with macro: int_out=0xFFFFFFFC (tie to even, -4).
4. Saturation cases:
   - 0x4F000000 (2^31) -> 0x7FFFFFFF, ovf=1;
   - 0xCF000000 -> 0x80000000, ovf=0;
   - 0x7F800001 (NaN) -> 0x80000000, ovf=1;
   - each with done 1 edge after the start edge.
5. Start 0x3F800001 (n=23). Drive rst=0 asynchronously mid-CALC, between clock edges:
   - required: busy=0, done=0, int_out=0 immediately.
   - After release, a new start with 0x40400000 (3.0) gives int_out=0x00000003.
6. start pulsed during CALC and during DONE: no effect. The result of the original operand is unchanged.
